// File: rtl/audio_i2s_pkg.sv
// Shared constants and payload types for the I2S transmitter slice.
package audio_i2s_pkg;

   localparam int unsigned SAMPLE_W        = 16;
   localparam int unsigned FRAME_W         = 2 * SAMPLE_W;
   localparam int unsigned SLOTS_PER_FRAME = 64;
   localparam int unsigned SLOT_W          = $clog2(SLOTS_PER_FRAME);
   localparam int unsigned DATA_FIRST_SLOT = 1;
   localparam int unsigned ACC_W           = 21;
   localparam int unsigned MCLK_INC_DEF    = 245760;
   localparam int unsigned MCLK_MOD_DEF    = 742500;

   typedef struct packed {
      logic [SAMPLE_W-1:0] left;
      logic [SAMPLE_W-1:0] right;
   } stereo_t;

endpackage

// File: rtl/audio_i2s_if.sv
// Upstream stereo-sample valid/ready handshake.
interface audio_i2s_if;
   import audio_i2s_pkg::*;

   logic                sample_valid;
   logic                sample_ready;
   logic [SAMPLE_W-1:0] sample_left;
   logic [SAMPLE_W-1:0] sample_right;

   modport master (output sample_valid, sample_left, sample_right, input sample_ready);
   modport slave  (input sample_valid, sample_left, sample_right, output sample_ready);

endinterface

// File: rtl/audio_i2s_fifo.sv
// Synchronous show-ahead FIFO holding stereo frames between upstream and the serializer.
module audio_fifo
   import audio_i2s_pkg::*;
#(
   parameter int unsigned AW = 2,
   parameter int unsigned W  = FRAME_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [AW:0]  level,
   output logic         full,
   output logic         empty
);

   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned LVL_W = AW + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [LVL_W-1:0] lvl_q, lvl_d;
   logic             do_push, do_pop;

   assign full  = (lvl_q == LVL_W'(DEPTH));
   assign empty = (lvl_q == '0);
   assign level = lvl_q;
   assign dout  = mem_q[rd_q];

   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      wr_d    = wr_q + AW'(do_push);
      rd_d    = rd_q + AW'(do_pop);
      lvl_d   = lvl_q;
      case ({do_push, do_pop})
         2'b10:   lvl_d = lvl_q + LVL_W'(1);
         2'b01:   lvl_d = lvl_q - LVL_W'(1);
         default: lvl_d = lvl_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and level.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/audio_i2s.sv
// I2S transmitter: fractional MCLK generator, SCLK/LRCK divider and MSB-first serializer
// fed from a small stereo-frame FIFO.
module audio_i2s
   import audio_i2s_pkg::*;
#(
   parameter int unsigned MCLK_INC = MCLK_INC_DEF,
   parameter int unsigned MCLK_MOD = MCLK_MOD_DEF,
   parameter int unsigned FIFO_AW  = 2
) (
   input  logic             clock,
   input  logic             reset,
   audio_i2s_if.slave       smp,
   output logic             audio_mclk,
   output logic             audio_lrck,
   output logic             audio_dac,
   output logic             underrun,
   output logic [FIFO_AW:0] fifo_level
);

   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam int unsigned HALF_W = SLOT_W - 1;
   localparam int unsigned BIT_W  = $clog2(SAMPLE_W);

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              mclk_q, mclk_d;
   logic [1:0]        div_q, div_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic              lrck_q, lrck_d;
   logic              dac_q, dac_d;
   logic              und_q, und_d;
   stereo_t           hold_q, hold_d;

   logic [SUM_W-1:0]    acc_sum;
   logic                ovf, mclk_rise, sclk_fall;
   logic [HALF_W-1:0]   half_pos;
   logic [BIT_W-1:0]    bit_idx;
   logic [SAMPLE_W-1:0] word;

   logic    fifo_push, fifo_pop, fifo_full, fifo_empty;
   stereo_t fifo_din, fifo_dout;

   assign fifo_din.left     = smp.sample_left;
   assign fifo_din.right    = smp.sample_right;
   assign smp.sample_ready  = ~fifo_full;
   assign fifo_push         = smp.sample_valid & ~fifo_full;

   audio_fifo #(
      .AW (FIFO_AW),
      .W  (FRAME_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      acc_sum   = SUM_W'(acc_q) + SUM_W'(MCLK_INC);
      ovf       = (acc_sum >= SUM_W'(MCLK_MOD));
      acc_d     = ovf ? ACC_W'(acc_sum - SUM_W'(MCLK_MOD)) : ACC_W'(acc_sum);
      mclk_d    = mclk_q ^ ovf;
      mclk_rise = ovf & ~mclk_q;
      div_d     = div_q + 2'(mclk_rise);
      // SCLK is div[1]; it falls when div wraps 3 -> 0.
      sclk_fall = mclk_rise & (div_q == 2'd3);

      slot_d   = slot_q;
      lrck_d   = lrck_q;
      dac_d    = dac_q;
      hold_d   = hold_q;
      und_d    = 1'b0;
      fifo_pop = 1'b0;
      half_pos = '0;
      bit_idx  = '0;
      word     = '0;

      if (sclk_fall) begin
         slot_d   = slot_q + SLOT_W'(1);
         lrck_d   = slot_d[SLOT_W-1];
         half_pos = slot_d[HALF_W-1:0];
         word     = lrck_d ? hold_q.right : hold_q.left;
         bit_idx  = BIT_W'(HALF_W'(SAMPLE_W - 1 + DATA_FIRST_SLOT) - half_pos);
         dac_d    = 1'b0;
         if (half_pos >= HALF_W'(DATA_FIRST_SLOT) &&
             half_pos <  HALF_W'(DATA_FIRST_SLOT + SAMPLE_W)) begin
            dac_d = word[bit_idx];
         end
         // Frame load: no bypass, a push in this same cycle is not yet visible.
         if (slot_d == '0) begin
            if (fifo_empty) begin
               und_d = 1'b1;
            end else begin
               fifo_pop = 1'b1;
               hold_d   = fifo_dout;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q  <= '0;
         mclk_q <= 1'b0;
         div_q  <= '0;
         slot_q <= '0;
         lrck_q <= 1'b0;
         dac_q  <= 1'b0;
         und_q  <= 1'b0;
         hold_q <= '0;
      end else begin
         acc_q  <= acc_d;
         mclk_q <= mclk_d;
         div_q  <= div_d;
         slot_q <= slot_d;
         lrck_q <= lrck_d;
         dac_q  <= dac_d;
         und_q  <= und_d;
         hold_q <= hold_d;
      end
   end

   assign audio_mclk = mclk_q;
   assign audio_lrck = lrck_q;
   assign audio_dac  = dac_q;
   assign underrun   = und_q;

endmodule

// File: tb/tb_audio_i2s.sv
// Self-checking bench for audio_i2s: closed-form clock/slot model, frame-level FIFO model,
// table-driven serial-format vectors and directed corner-case sequences.
module tb_audio_i2s;
   import audio_i2s_pkg::*;

   localparam longint INC   = 245760;
   localparam longint MOD   = 742500;
   localparam int     DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       audio_mclk, audio_lrck, audio_dac, underrun;
   logic [2:0] fifo_level;

   always #5 clock = ~clock;

   audio_i2s_if smp();

   audio_i2s #(.MCLK_INC(245760), .MCLK_MOD(742500), .FIFO_AW(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .smp        (smp),
      .audio_mclk (audio_mclk),
      .audio_lrck (audio_lrck),
      .audio_dac  (audio_dac),
      .underrun   (underrun),
      .fifo_level (fifo_level)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no event within bound, required one (t=%0t)", nm, $time);
   endtask

   // Closed-form timing: after k running cycles, MCLK has toggled floor(k*INC/MOD) times.
   function automatic longint toggles_at(longint k);
      return (k * INC) / MOD;
   endfunction

   function automatic longint falls_at(longint k);
      return ((toggles_at(k) + 1) / 2) / 4;
   endfunction

   function automatic logic exp_dac(int slot, logic [15:0] hl, logic [15:0] hr);
      int          h;
      logic [15:0] w;
      h = slot % 32;
      w = (slot >= 32) ? hr : hl;
      if (h >= 1 && h <= 16) return w[16-h];
      return 1'b0;
   endfunction

   // Reference model, advanced on each active edge.
   longint      m_k = 0;
   logic [31:0] mq[$];
   logic [15:0] m_hl = '0, m_hr = '0;
   logic        m_und = 1'b0;
   logic        m_mclk = 1'b0;
   int          m_slot = 0;

   always @(posedge clock) begin : model_b
      bit     ready_pre;
      bit     load;
      longint f_old, f_new;
      if (reset) begin
         m_k = 0;
         mq.delete();
         m_hl  = '0;
         m_hr  = '0;
         m_und = 1'b0;
      end else begin
         ready_pre = (mq.size() != DEPTH);
         f_old = falls_at(m_k);
         m_k++;
         f_new = falls_at(m_k);
         load  = (f_new != f_old) && (f_new % 64 == 0);
         m_und = load && (mq.size() == 0);
         if (load && mq.size() > 0) {m_hl, m_hr} = mq.pop_front();
         if (smp.sample_valid && ready_pre) mq.push_back({smp.sample_left, smp.sample_right});
      end
      m_slot = int'(falls_at(m_k) % 64);
      m_mclk = 1'(toggles_at(m_k) % 2);
   end

   // Per-cycle comparison plus capture of the serial stream per slot.
   logic        mon_en = 1'b0;
   logic [63:0] cur_bits = '0, last_bits = '0, cur_lr = '0, last_lr = '0;
   int          frames_done = 0;
   int          prev_slot = 0;

   always @(negedge clock) begin : mon_b
      logic [7:0] act, exp;
      if (mon_en) begin
         act = {audio_mclk, audio_lrck, audio_dac, underrun, smp.sample_ready, fifo_level};
         exp = {m_mclk, (m_slot >= 32), exp_dac(m_slot, m_hl, m_hr), m_und,
                (mq.size() != DEPTH), 3'(mq.size())};
         check("cycle", 64'(act), 64'(exp));
         if (m_slot != prev_slot) begin
            if (m_slot == 0) begin
               last_bits = cur_bits;
               last_lr   = cur_lr;
               frames_done++;
            end
            cur_bits[m_slot] = audio_dac;
            cur_lr[m_slot]   = audio_lrck;
            prev_slot = m_slot;
         end
      end
   end

   task automatic wait_slot(int s, string nm);
      for (int i = 0; i < 4000; i++) begin
         @(negedge clock);
         if (m_slot == s) return;
      end
      timeout_fail(nm);
   endtask

   task automatic wait_load(string nm);
      int last;
      last = m_slot;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clock);
         if (m_slot == 0 && last != 0) return;
         last = m_slot;
      end
      timeout_fail(nm);
   endtask

   task automatic wait_frames(int target, string nm);
      for (int i = 0; i < 6000; i++) begin
         if (frames_done >= target) return;
         @(negedge clock);
      end
      timeout_fail(nm);
   endtask

   task automatic push(logic [15:0] l, logic [15:0] r, string nm);
      bit rdy;
      smp.sample_left  = l;
      smp.sample_right = r;
      smp.sample_valid = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         rdy = smp.sample_ready;
         @(negedge clock);
         if (rdy) begin
            smp.sample_valid = 1'b0;
            return;
         end
      end
      smp.sample_valid = 1'b0;
      timeout_fail(nm);
   endtask

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      logic [15:0] exp_l;
      logic [15:0] exp_r;
   } vec_t;

   initial begin
      vec_t        tbl[4];
      longint      exp_tog;
      int          tog, rises, lr_falls, fc, exp_frames, diff;
      logic        pm, pl;
      logic [15:0] got_l, got_r;

      tbl[0] = '{16'hA5C3, 16'h1234, 16'b1010010111000011, 16'b0001001000110100};
      tbl[1] = '{16'h8000, 16'h7FFF, 16'b1000000000000000, 16'b0111111111111111};
      tbl[2] = '{16'hFFFF, 16'h0001, 16'b1111111111111111, 16'b0000000000000001};
      tbl[3] = '{16'h0F0F, 16'hF00F, 16'b0000111100001111, 16'b1111000000001111};

      smp.sample_valid = 1'b0;
      smp.sample_left  = '0;
      smp.sample_right = '0;
      reset = 1'b1;
      @(posedge clock);
      mon_en = 1'b1;

      // Reset held for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("reset_outs", 64'({audio_mclk, audio_lrck, audio_dac, underrun,
                                  smp.sample_ready, fifo_level}), 64'(8'b0000_1000));
      end
      reset = 1'b0;

      // MCLK / LRCK rate over a fixed window from reset release.
      tog = 0; rises = 0; lr_falls = 0; pm = 1'b0; pl = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clock);
         if (i == 0)
            check("release_outs", 64'({audio_mclk, audio_lrck, audio_dac, underrun,
                                       smp.sample_ready, fifo_level}), 64'(8'b0000_1000));
         if (audio_mclk !== pm) tog++;
         if (!pm && audio_mclk) rises++;
         if (pl && !audio_lrck) lr_falls++;
         pm = audio_mclk;
         pl = audio_lrck;
      end
      exp_tog = (longint'(20000) * INC) / MOD;
      check("mclk_toggles", 64'(tog), 64'(exp_tog));
      check("mclk_rises", 64'(rises), 64'((exp_tog + 1) / 2));
      exp_frames = int'(exp_tog / 512);
      diff = lr_falls - exp_frames;
      n_checks++;
      if (diff > 1 || diff < -1) begin
         n_fail++;
         $display("FAIL lrck_periods: got %0d, required %0d +/-1", lr_falls, exp_frames);
      end

      // Serial format vectors.
      for (int v = 0; v < 4; v++) begin
         wait_slot(5, "t3_slot");
         push(tbl[v].l, tbl[v].r, "t3_push");
         fc = frames_done;
         wait_frames(fc + 2, "t3_frame");
         for (int j = 0; j < 16; j++) begin
            got_l[15-j] = last_bits[1+j];
            got_r[15-j] = last_bits[33+j];
         end
         check("ser_left", 64'(got_l), 64'(tbl[v].exp_l));
         check("ser_right", 64'(got_r), 64'(tbl[v].exp_r));
         check("ser_idle_slots", last_bits & ~64'h0001_FFFE_0001_FFFE, 64'h0);
         check("ser_lrck", last_lr, 64'hFFFF_FFFF_0000_0000);
      end

      // FIFO full: five back-to-back pushes right after a load.
      wait_load("t4_load");
      for (int i = 0; i < 5; i++) begin
         smp.sample_left  = (i == 4) ? 16'hC0DE : 16'(32'h1000 + i);
         smp.sample_right = (i == 4) ? 16'hBEEF : 16'(32'h2000 + i);
         smp.sample_valid = 1'b1;
         @(negedge clock);
      end
      check("full_level", 64'(fifo_level), 64'd4);
      check("full_ready", 64'(smp.sample_ready), 64'd0);
      repeat (3) begin
         @(negedge clock);
         check("full_hold", 64'({smp.sample_ready, fifo_level}), 64'({1'b0, 3'd4}));
      end
      wait_load("t4_pop");
      check("pop_level", 64'(fifo_level), 64'd3);
      check("pop_ready", 64'(smp.sample_ready), 64'd1);
      @(negedge clock);
      check("refill_level", 64'(fifo_level), 64'd4);
      smp.sample_valid = 1'b0;

      // Underrun once the queue drains.
      repeat (4) wait_load("t5_drain");
      wait_load("t5_under");
      check("underrun_pulse", 64'(underrun), 64'd1);
      @(negedge clock);
      check("underrun_width", 64'(underrun), 64'd0);
      fc = frames_done;
      wait_frames(fc + 1, "t5_frame");
      for (int j = 0; j < 16; j++) begin
         got_l[15-j] = last_bits[1+j];
         got_r[15-j] = last_bits[33+j];
      end
      check("repeat_left", 64'(got_l), 64'(16'hC0DE));
      check("repeat_right", 64'(got_r), 64'(16'hBEEF));

      // Reset mid-frame with two frames queued.
      wait_load("t6_load");
      push(16'h1111, 16'h2222, "t6_push_a");
      push(16'h3333, 16'h4444, "t6_push_b");
      check("t6_queued", 64'(fifo_level), 64'd2);
      wait_slot(20, "t6_slot20");
      reset = 1'b1;
      @(negedge clock);
      check("midrst_outs", 64'({audio_mclk, audio_lrck, audio_dac, underrun,
                                smp.sample_ready, fifo_level}), 64'(8'b0000_1000));
      @(negedge clock);
      reset = 1'b0;
      wait_slot(31, "t6_slot31");
      check("lrck_slot31", 64'(audio_lrck), 64'd0);
      wait_slot(32, "t6_slot32");
      check("lrck_slot32", 64'(audio_lrck), 64'd1);
      wait_load("t6_first_load");
      check("first_load_underrun", 64'(underrun), 64'd1);

      // Randomized traffic: sparse (underruns) then dense (back-pressure).
      for (int i = 0; i < 8000; i++) begin
         @(negedge clock);
         smp.sample_valid = ($urandom_range(0, 1999) == 0);
         smp.sample_left  = 16'($urandom);
         smp.sample_right = 16'($urandom);
      end
      for (int i = 0; i < 8000; i++) begin
         @(negedge clock);
         smp.sample_valid = ($urandom_range(0, 29) == 0);
         smp.sample_left  = 16'($urandom);
         smp.sample_right = 16'($urandom);
      end
      smp.sample_valid = 1'b0;
      @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
